// File: rtl/trap_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : trap_ctrl
// Brief    : Machine-mode trap entry / MRET sequencer. Accepts one request
//            from the LSU->WBU boundary, walks the shared CSR write port
//            through a fixed write sequence, reads the target CSR and issues
//            a one-shot fetch redirect. busy_o covers the whole sequence.
// Options  : MTVAL_WRITE_EN - when defined, a W_MTVAL step writes the
//            latched trap value to mtval between mcause and mstatus.
// Revision : 1.0 - initial release
// ============================================================================
module trap_ctrl #(
    parameter logic [1:0] RESET_MSTATUS_MPP = 2'b11
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        excp_valid_i,
    input  logic [15:0] excp_bus_i,
    input  logic        xret_i,
    input  logic [31:0] excp_pc_i,
    input  logic [31:0] excp_tval_i,
    output logic        excp_ready_o,
    output logic [11:0] csr_raddr_o,
    input  logic [31:0] csr_rdata_i,
    output logic [11:0] csr_addr_o,
    output logic [31:0] csr_wdata_o,
    output logic        csr_we_o,
    output logic        redirect_valid_o,
    output logic [31:0] redirect_pc_o,
    input  logic        redirect_ready_i,
    output logic        busy_o,
    output logic [31:0] trap_cnt_o
);

    // CSR addresses touched by the sequence
    localparam logic [11:0] c_addr_mstatus = 12'h300;
    localparam logic [11:0] c_addr_mtvec   = 12'h305;
    localparam logic [11:0] c_addr_mepc    = 12'h341;
    localparam logic [11:0] c_addr_mcause  = 12'h342;
`ifdef MTVAL_WRITE_EN
    localparam logic [11:0] c_addr_mtval   = 12'h343;
`endif

    // Cause bits 10 and 14 are reserved codes and never raise a trap
    localparam logic [15:0] c_cause_mask = 16'hBBFF;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        W_MEPC    = 4'd1,
        W_MCAUSE  = 4'd2,
`ifdef MTVAL_WRITE_EN
        W_MTVAL   = 4'd3,
`endif
        W_MSTATUS = 4'd4,
        X_MSTATUS = 4'd5,
        RD_TGT    = 4'd6,
        REDIRECT  = 4'd7
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic [31:0] r_pc;
    logic [3:0]  r_cause;
    logic        r_is_trap;
    logic [31:0] r_target;
    logic [31:0] r_trap_cnt;

    logic [15:0] w_cause_bits;
    logic        w_cause_hit;
    logic [3:0]  w_cause_code;
    logic        w_accept;

`ifdef MTVAL_WRITE_EN
    logic [31:0] r_tval;
`else
    // Trap value has no destination when mtval is not written
    logic        w_unused_tval;
    assign w_unused_tval = ^excp_tval_i;
`endif

    assign w_cause_bits = excp_bus_i & c_cause_mask;
    assign w_cause_hit  = |w_cause_bits;
    assign w_accept     = (r_state == IDLE) && excp_valid_i;

    assign excp_ready_o = (r_state == IDLE);
    assign busy_o       = (r_state != IDLE);
    assign trap_cnt_o   = r_trap_cnt;

    // Priority encoder: lowest set cause index wins (scan high to low so the
    // last assignment is the lowest index)
    always_comb begin
        w_cause_code = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (w_cause_bits[i]) begin
                w_cause_code = 4'(i);
            end
        end
    end

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and CSR/redirect port drive; unused fields stay at zero
    always_comb begin
        w_next_state     = r_state;
        csr_raddr_o      = 12'h000;
        csr_addr_o       = 12'h000;
        csr_wdata_o      = 32'h0000_0000;
        csr_we_o         = 1'b0;
        redirect_valid_o = 1'b0;
        redirect_pc_o    = 32'h0000_0000;

        case (r_state)
            IDLE: begin
                // Exception beats MRET; a request with neither is dropped
                if (excp_valid_i) begin
                    if (w_cause_hit) begin
                        w_next_state = W_MEPC;
                    end else if (xret_i) begin
                        w_next_state = X_MSTATUS;
                    end
                end
            end

            W_MEPC: begin
                csr_addr_o   = c_addr_mepc;
                csr_wdata_o  = r_pc & ~32'h0000_0003;
                csr_we_o     = 1'b1;
                w_next_state = W_MCAUSE;
            end

            W_MCAUSE: begin
                csr_addr_o   = c_addr_mcause;
                csr_wdata_o  = {28'h000_0000, r_cause};
                csr_we_o     = 1'b1;
`ifdef MTVAL_WRITE_EN
                w_next_state = W_MTVAL;
`else
                w_next_state = W_MSTATUS;
`endif
            end

`ifdef MTVAL_WRITE_EN
            W_MTVAL: begin
                csr_addr_o   = c_addr_mtval;
                csr_wdata_o  = r_tval;
                csr_we_o     = 1'b1;
                w_next_state = W_MSTATUS;
            end
`endif

            W_MSTATUS: begin
                // Trap entry: MPIE <- MIE, MIE <- 0, MPP <- configured mode
                csr_raddr_o        = c_addr_mstatus;
                csr_addr_o         = c_addr_mstatus;
                csr_wdata_o        = csr_rdata_i;
                csr_wdata_o[7]     = csr_rdata_i[3];
                csr_wdata_o[3]     = 1'b0;
                csr_wdata_o[12:11] = RESET_MSTATUS_MPP;
                csr_we_o           = 1'b1;
                w_next_state       = RD_TGT;
            end

            X_MSTATUS: begin
                // MRET: MIE <- MPIE, MPIE <- 1, MPP <- configured mode
                csr_raddr_o        = c_addr_mstatus;
                csr_addr_o         = c_addr_mstatus;
                csr_wdata_o        = csr_rdata_i;
                csr_wdata_o[3]     = csr_rdata_i[7];
                csr_wdata_o[7]     = 1'b1;
                csr_wdata_o[12:11] = RESET_MSTATUS_MPP;
                csr_we_o           = 1'b1;
                w_next_state       = RD_TGT;
            end

            RD_TGT: begin
                // Trap jumps to mtvec (direct mode), MRET returns to mepc
                csr_raddr_o  = r_is_trap ? c_addr_mtvec : c_addr_mepc;
                w_next_state = REDIRECT;
            end

            REDIRECT: begin
                redirect_valid_o = 1'b1;
                redirect_pc_o    = r_target;
                if (redirect_ready_i) begin
                    w_next_state = IDLE;
                end
            end

            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Request capture, redirect target capture and trap counter
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pc       <= 32'h0000_0000;
            r_cause    <= 4'd0;
            r_is_trap  <= 1'b0;
            r_target   <= 32'h0000_0000;
            r_trap_cnt <= 32'h0000_0000;
`ifdef MTVAL_WRITE_EN
            r_tval     <= 32'h0000_0000;
`endif
        end else begin
            if (w_accept) begin
                r_pc      <= excp_pc_i;
                r_cause   <= w_cause_code;
                r_is_trap <= w_cause_hit;
`ifdef MTVAL_WRITE_EN
                r_tval    <= excp_tval_i;
`endif
            end
            // Both mtvec (MODE ignored) and mepc are word-aligned the same way
            if (r_state == RD_TGT) begin
                r_target <= {csr_rdata_i[31:2], 2'b00};
            end
            if ((r_state == REDIRECT) && redirect_ready_i && r_is_trap) begin
                r_trap_cnt <= r_trap_cnt + 32'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_trap_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_trap_ctrl
// Brief    : Scoreboard bench for trap_ctrl with a small CSR file model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_trap_ctrl;

`ifdef MTVAL_WRITE_EN
    localparam int TRAP_LAT = 6;
`else
    localparam int TRAP_LAT = 5;
`endif
    localparam int XRET_LAT = 3;

    logic        clock;
    logic        reset;
    logic        excp_valid_i;
    logic [15:0] excp_bus_i;
    logic        xret_i;
    logic [31:0] excp_pc_i;
    logic [31:0] excp_tval_i;
    logic        excp_ready_o;
    logic [11:0] csr_raddr_o;
    logic [31:0] csr_rdata_i;
    logic [11:0] csr_addr_o;
    logic [31:0] csr_wdata_o;
    logic        csr_we_o;
    logic        redirect_valid_o;
    logic [31:0] redirect_pc_o;
    logic        redirect_ready_i;
    logic        busy_o;
    logic [31:0] trap_cnt_o;

    trap_ctrl #(.RESET_MSTATUS_MPP(2'b11)) dut (
        .clock            (clock),
        .reset            (reset),
        .excp_valid_i     (excp_valid_i),
        .excp_bus_i       (excp_bus_i),
        .xret_i           (xret_i),
        .excp_pc_i        (excp_pc_i),
        .excp_tval_i      (excp_tval_i),
        .excp_ready_o     (excp_ready_o),
        .csr_raddr_o      (csr_raddr_o),
        .csr_rdata_i      (csr_rdata_i),
        .csr_addr_o       (csr_addr_o),
        .csr_wdata_o      (csr_wdata_o),
        .csr_we_o         (csr_we_o),
        .redirect_valid_o (redirect_valid_o),
        .redirect_pc_o    (redirect_pc_o),
        .redirect_ready_i (redirect_ready_i),
        .busy_o           (busy_o),
        .trap_cnt_o       (trap_cnt_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int n_writes = 0;

    logic [43:0] exp_wr[$];   // {addr, data}
    logic [31:0] exp_rd[$];

    // CSR file model: combinational read, write at the clock edge
    logic [31:0] csr_mem [0:4095];
    logic        poke_en = 1'b0;
    logic [11:0] poke_addr = 12'h000;
    logic [31:0] poke_data = 32'h0;

    always_comb csr_rdata_i = csr_mem[csr_raddr_o];

    always @(posedge clock) begin
        if (poke_en) begin
            csr_mem[poke_addr] <= poke_data;
        end else if (reset && csr_we_o) begin
            csr_mem[csr_addr_o] <= csr_wdata_o;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Monitor: every CSR write and every redirect handshake is popped and compared
    always @(negedge clock) begin
        if (reset) begin
            if (csr_we_o) begin
                n_writes++;
                if (exp_wr.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL csr_write_unexpected: got addr %h data %h, required no write",
                             csr_addr_o, csr_wdata_o);
                end else begin
                    logic [43:0] e;
                    e = exp_wr.pop_front();
                    chk("csr_write_addr", {20'h0, csr_addr_o}, {20'h0, e[43:32]});
                    chk("csr_write_data", csr_wdata_o, e[31:0]);
                end
            end
            if (redirect_valid_o && redirect_ready_i) begin
                if (exp_rd.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL redirect_unexpected: got pc %h, required none", redirect_pc_o);
                end else begin
                    chk("redirect_pc", redirect_pc_o, exp_rd.pop_front());
                end
            end
        end
    end

    task automatic poke(input logic [11:0] a, input logic [31:0] d);
        @(posedge clock);
        #1;
        poke_addr = a;
        poke_data = d;
        poke_en   = 1'b1;
        @(posedge clock);
        #1;
        poke_en   = 1'b0;
    endtask

    task automatic push_trap(input logic [31:0] mepc, input logic [31:0] code,
                             input logic [31:0] tval, input logic [31:0] mst,
                             input logic [31:0] tgt);
        exp_wr.push_back({12'h341, mepc});
        exp_wr.push_back({12'h342, code});
`ifdef MTVAL_WRITE_EN
        exp_wr.push_back({12'h343, tval});
`else
        if (tval == 32'h0) begin end
`endif
        exp_wr.push_back({12'h300, mst});
        exp_rd.push_back(tgt);
    endtask

    // Issue one request, then measure cycles from the accept edge to redirect_valid
    task automatic do_req(input logic [15:0] bus, input logic xr, input logic [31:0] pc,
                          input logic [31:0] tval, input int exp_lat, input logic rdy);
        int lat;
        @(posedge clock);
        #1;
        excp_valid_i     = 1'b1;
        excp_bus_i       = bus;
        xret_i           = xr;
        excp_pc_i        = pc;
        excp_tval_i      = tval;
        redirect_ready_i = rdy;
        chk("ready_before_accept", {31'h0, excp_ready_o}, 32'h1);
        @(posedge clock);
        #1;
        excp_valid_i = 1'b0;
        excp_bus_i   = 16'h0;
        xret_i       = 1'b0;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clock);
            if (redirect_valid_o) begin
                lat = k;
                break;
            end
        end
        chk("redirect_latency", 32'(lat), 32'(exp_lat));
    endtask

    // After a handshake edge: redirect dropped, back in IDLE, counter value
    task automatic post_checks(input logic [31:0] cnt);
        @(negedge clock);
        chk("redirect_valid_after_hs", {31'h0, redirect_valid_o}, 32'h0);
        chk("busy_after_hs", {31'h0, busy_o}, 32'h0);
        chk("ready_after_hs", {31'h0, excp_ready_o}, 32'h1);
        chk("trap_cnt", trap_cnt_o, cnt);
    endtask

    initial begin
        int      wr_before;
        logic [31:0] mst_saved;

        reset            = 1'b0;
        excp_valid_i     = 1'b0;
        excp_bus_i       = 16'h0;
        xret_i           = 1'b0;
        excp_pc_i        = 32'h0;
        excp_tval_i      = 32'h0;
        redirect_ready_i = 1'b0;

        // Reset state
        repeat (2) @(negedge clock);
        chk("rst_ready", {31'h0, excp_ready_o}, 32'h1);
        chk("rst_busy", {31'h0, busy_o}, 32'h0);
        chk("rst_we", {31'h0, csr_we_o}, 32'h0);
        chk("rst_redirect_valid", {31'h0, redirect_valid_o}, 32'h0);
        chk("rst_trap_cnt", trap_cnt_o, 32'h0);
        chk("rst_raddr", {20'h0, csr_raddr_o}, 32'h0);
        @(posedge clock);
        #1 reset = 1'b1;

        // Basic trap entry
        poke(12'h300, 32'h0000_0008);
        poke(12'h305, 32'h8000_1001);
        push_trap(32'h8000_0100, 32'd2, 32'hDEAD_BEEF, 32'h0000_1880, 32'h8000_1000);
        do_req(16'h0004, 1'b0, 32'h8000_0102, 32'hDEAD_BEEF, TRAP_LAT, 1'b1);
        @(posedge clock);
        post_checks(32'd1);

        // MRET
        poke(12'h341, 32'h8000_0204);
        exp_wr.push_back({12'h300, 32'h0000_1888});
        exp_rd.push_back(32'h8000_0204);
        do_req(16'h0000, 1'b1, 32'h8000_0210, 32'h0, XRET_LAT, 1'b1);
        @(posedge clock);
        post_checks(32'd1);

        // Exception beats MRET; lowest cause index wins
        push_trap(32'h8000_0300, 32'd3, 32'h1111_2222, 32'h0000_1880, 32'h8000_1000);
        do_req(16'h0808, 1'b1, 32'h8000_0300, 32'h1111_2222, TRAP_LAT, 1'b1);
        @(posedge clock);
        post_checks(32'd2);

        // Redirect backpressure with requests pulsing while busy
        poke(12'h305, 32'h8000_2002);
        push_trap(32'h8000_0404, 32'd15, 32'h3333_4444, 32'h0000_1800, 32'h8000_2000);
        do_req(16'h8000, 1'b0, 32'h8000_0404, 32'h3333_4444, TRAP_LAT, 1'b0);
        for (int h = 0; h < 4; h++) begin
            @(posedge clock);
            #1;
            excp_valid_i = 1'b1;
            excp_bus_i   = 16'h0001;
            @(negedge clock);
            chk("bp_valid", {31'h0, redirect_valid_o}, 32'h1);
            chk("bp_pc", redirect_pc_o, 32'h8000_2000);
            chk("bp_busy", {31'h0, busy_o}, 32'h1);
        end
        @(posedge clock);
        #1 redirect_ready_i = 1'b1;   // excp_valid stays high through the handshake
        @(posedge clock);
        #1;
        excp_valid_i = 1'b0;
        excp_bus_i   = 16'h0;
        post_checks(32'd3);

        // Request with only reserved cause bits and no MRET is dropped
        wr_before = n_writes;
        @(posedge clock);
        #1;
        excp_valid_i = 1'b1;
        excp_bus_i   = 16'h4400;
        xret_i       = 1'b0;
        @(posedge clock);
        #1;
        excp_valid_i = 1'b0;
        excp_bus_i   = 16'h0;
        repeat (6) @(negedge clock);
        chk("drop_busy", {31'h0, busy_o}, 32'h0);
        chk("drop_writes", 32'(n_writes - wr_before), 32'h0);
        chk("drop_trap_cnt", trap_cnt_o, 32'd3);

        // Reset asserted in W_MCAUSE
        mst_saved = csr_mem[12'h300];
        push_trap(32'h8000_0600, 32'd5, 32'h0, 32'h0000_1800, 32'h8000_2000);
        @(posedge clock);
        #1;
        excp_valid_i = 1'b1;
        excp_bus_i   = 16'h0020;
        excp_pc_i    = 32'h8000_0600;
        @(posedge clock);
        #1;
        excp_valid_i = 1'b0;
        excp_bus_i   = 16'h0;
        @(negedge clock);
        chk("mepc_step_addr", {20'h0, csr_addr_o}, 32'h341);
        @(posedge clock);
        #2 reset = 1'b0;
        #1;
        chk("midrst_we", {31'h0, csr_we_o}, 32'h0);
        chk("midrst_busy", {31'h0, busy_o}, 32'h0);
        chk("midrst_ready", {31'h0, excp_ready_o}, 32'h1);
        chk("midrst_redirect", {31'h0, redirect_valid_o}, 32'h0);
        chk("midrst_trap_cnt", trap_cnt_o, 32'h0);
        exp_wr.delete();
        exp_rd.delete();
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        repeat (8) @(negedge clock);
        chk("midrst_idle", {31'h0, busy_o}, 32'h0);
        chk("midrst_mstatus_kept", csr_mem[12'h300], mst_saved);

        // Trap counter wrap
        @(negedge clock);
        force dut.r_trap_cnt = 32'hFFFF_FFFF;
        @(posedge clock);
        #1 release dut.r_trap_cnt;
        @(negedge clock);
        chk("cnt_preload", trap_cnt_o, 32'hFFFF_FFFF);
        push_trap(32'h8000_0504, 32'd1, 32'h0000_0005, 32'h0000_1800, 32'h8000_2000);
        do_req(16'h0002, 1'b0, 32'h8000_0507, 32'h0000_0005, TRAP_LAT, 1'b1);
        @(posedge clock);
        post_checks(32'h0);

        repeat (3) @(negedge clock);
        chk("wr_queue_drained", 32'(exp_wr.size()), 32'h0);
        chk("rd_queue_drained", 32'(exp_rd.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time bound so the bench always ends
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, required completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
